// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer for the RV32 core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the memory
// handshakes, IR load, PC update and register-file write. A memory ack that
// does not arrive within TIMEOUT wait cycles parks the FSM in a sticky error
// state, and only reset leaves that state.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | instruction fetch request outstanding
// DECODE | capture decoder strobes
// EXEC   | choose memory access or straight to writeback
// MEM    | data memory access outstanding
// WB     | PC update, register write, retire
// ERR    | memory timeout, held until reset
module core_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             lw_en,
    input  logic             sw_en,
    input  logic             wr_en,
    input  logic             offset_en,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_offset_sel,
    output logic             bus_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERR    = 3'd6
    } state_t;

    // Wide enough to count up to TIMEOUT-1; when TIMEOUT is 0 the counter
    // free-runs and is never compared.
    localparam int          WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            cur_state;
    state_t            nxt_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_done;
    logic              lw_q;
    logic              sw_q;
    logic              wr_q;
    logic              off_q;

    assign wait_done = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
    assign state     = cur_state;

    // State register
    always_ff @(posedge clk) begin
        if (rst) cur_state <= IDLE;
        else     cur_state <= nxt_state;
    end

    // Next-state decode; an ack in the last allowed wait cycle still completes
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:    if (run) nxt_state = FETCH;
            FETCH: begin
                if (imem_ack)       nxt_state = DECODE;
                else if (wait_done) nxt_state = ERR;
            end
            DECODE:  nxt_state = EXEC;
            EXEC:    nxt_state = (lw_q || sw_q) ? MEM : WB;
            MEM: begin
                if (dmem_ack)       nxt_state = WB;
                else if (wait_done) nxt_state = ERR;
            end
            WB:      nxt_state = run ? FETCH : IDLE;
            ERR:     nxt_state = ERR;
            default: nxt_state = IDLE;
        endcase
    end

    // Moore output decode; ir_load is the only combinational handshake term
    always_comb begin
        imem_req      = 1'b0;
        dmem_rd       = 1'b0;
        dmem_wr       = 1'b0;
        rf_we         = 1'b0;
        pc_we         = 1'b0;
        pc_offset_sel = 1'b0;
        bus_err       = 1'b0;
        case (cur_state)
            FETCH: imem_req = 1'b1;
            MEM: begin
                dmem_rd = lw_q;
                dmem_wr = sw_q & ~lw_q;
            end
            WB: begin
                pc_we         = 1'b1;
                pc_offset_sel = off_q;
                rf_we         = wr_q & ~sw_q;
            end
            ERR:     bus_err = 1'b1;
            default: ;
        endcase
        ir_load = imem_req & imem_ack;
    end

    // Memory wait counter: cleared on entry to FETCH/MEM, counts ack-less cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((nxt_state != cur_state) && ((nxt_state == FETCH) || (nxt_state == MEM))) begin
            wait_cnt <= '0;
        end else if (((cur_state == FETCH) && !imem_ack) || ((cur_state == MEM) && !dmem_ack)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Decoder strobes captured once per instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            lw_q  <= 1'b0;
            sw_q  <= 1'b0;
            wr_q  <= 1'b0;
            off_q <= 1'b0;
        end else if (cur_state == DECODE) begin
            lw_q  <= lw_en;
            sw_q  <= sw_en;
            wr_q  <= wr_en;
            off_q <= offset_en;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst)                  instr_cnt <= '0;
        else if (cur_state == WB) instr_cnt <= instr_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: each step drives inputs, pushes the
// expected outputs for that cycle to a scoreboard and compares them mid-cycle.
module tb_core_sequencer;

    localparam int TO = 4;
    localparam int CW = 3;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_ERR = 3'd6;

    // strobes = {imem_req, ir_load, dmem_rd, dmem_wr, rf_we, pc_we, pc_offset_sel, bus_err}
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_REQ  = 8'b1000_0000;
    localparam logic [7:0] O_LD   = 8'b1100_0000;
    localparam logic [7:0] O_RD   = 8'b0010_0000;
    localparam logic [7:0] O_WR   = 8'b0001_0000;
    localparam logic [7:0] O_RF   = 8'b0000_1000;
    localparam logic [7:0] O_PC   = 8'b0000_0100;
    localparam logic [7:0] O_OFF  = 8'b0000_0010;
    localparam logic [7:0] O_ERR  = 8'b0000_0001;

    typedef struct packed {
        logic [2:0]    st;
        logic [7:0]    so;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst, run, lw_en, sw_en, wr_en, offset_en, imem_ack, dmem_ack;
    logic imem_req, ir_load, dmem_rd, dmem_wr, rf_we, pc_we, pc_offset_sel, bus_err;
    logic [2:0]    state;
    logic [CW-1:0] instr_cnt;

    exp_t          sb[$];
    string         tag_q[$];
    logic [CW-1:0] exp_cnt;
    int            checks = 0;
    int            errors = 0;

    core_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run),
        .lw_en(lw_en), .sw_en(sw_en), .wr_en(wr_en), .offset_en(offset_en),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_load(ir_load), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .rf_we(rf_we), .pc_we(pc_we), .pc_offset_sel(pc_offset_sel), .bus_err(bus_err),
        .state(state), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_dec(input logic lw, input logic sw, input logic wr, input logic off);
        lw_en = lw; sw_en = sw; wr_en = wr; offset_en = off;
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        logic [7:0] so_obs;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed empty expected entry");
            return;
        end
        e = sb.pop_front();
        t = tag_q.pop_front();
        so_obs = {imem_req, ir_load, dmem_rd, dmem_wr, rf_we, pc_we, pc_offset_sel, bus_err};
        checks++;
        assert ({state, so_obs} === {e.st, e.so}) else begin
            errors++;
            $error("FAIL %s state/strobes observed %0d/%b expected %0d/%b", t, state, so_obs, e.st, e.so);
        end
        checks++;
        assert (instr_cnt === e.cnt) else begin
            errors++;
            $error("FAIL %s instr_cnt observed %0d expected %0d", t, instr_cnt, e.cnt);
        end
    endtask

    // One clock cycle: drive, queue expectation, compare at negedge, advance
    task automatic step(input logic r, input logic ru, input logic ia, input logic da,
                        input logic [2:0] st, input logic [7:0] so, input string tag);
        exp_t e;
        rst = r; run = ru; imem_ack = ia; dmem_ack = da;
        e.st = st; e.so = so; e.cnt = exp_cnt;
        sb.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        check_out();
        if (r)               exp_cnt = '0;
        else if (st == S_WB) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        set_dec(0, 0, 0, 0);
        exp_cnt = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, S_IDLE, O_NONE, "reset_state");
        step(0, 0, 0, 0, S_IDLE, O_NONE, "idle_hold");

        // ALU op writing rd, zero-wait fetch: 4 cycles FETCH..WB
        set_dec(0, 0, 1, 0);
        step(0, 1, 0, 0, S_IDLE,  O_NONE,      "alu_idle");
        step(0, 1, 1, 0, S_FETCH, O_LD,        "alu_fetch");
        step(0, 1, 0, 0, S_DEC,   O_NONE,      "alu_decode");
        step(0, 1, 0, 0, S_EXEC,  O_NONE,      "alu_exec");
        step(0, 0, 0, 0, S_WB,    O_RF | O_PC, "alu_wb");
        step(0, 0, 0, 0, S_IDLE,  O_NONE,      "alu_done");

        // Load, dmem ack on the last allowed wait cycle; stray imem_ack ignored
        set_dec(1, 0, 1, 0);
        step(0, 1, 0, 0, S_IDLE,  O_NONE,      "lw_idle");
        step(0, 1, 1, 0, S_FETCH, O_LD,        "lw_fetch");
        step(0, 1, 0, 0, S_DEC,   O_NONE,      "lw_decode");
        step(0, 1, 0, 0, S_EXEC,  O_NONE,      "lw_exec");
        step(0, 1, 1, 0, S_MEM,   O_RD,        "lw_mem0");
        step(0, 1, 0, 0, S_MEM,   O_RD,        "lw_mem1");
        step(0, 1, 0, 0, S_MEM,   O_RD,        "lw_mem2");
        step(0, 1, 0, 1, S_MEM,   O_RD,        "lw_mem3_ack");
        step(0, 0, 0, 0, S_WB,    O_RF | O_PC, "lw_wb");
        step(0, 0, 0, 0, S_IDLE,  O_NONE,      "lw_done");

        // Store; dmem_ack during FETCH must not complete the fetch; WB -> FETCH
        set_dec(0, 1, 0, 0);
        step(0, 1, 0, 0, S_IDLE,  O_NONE, "sw_idle");
        step(0, 1, 0, 1, S_FETCH, O_REQ,  "sw_fetch_wait");
        step(0, 1, 1, 0, S_FETCH, O_LD,   "sw_fetch");
        step(0, 1, 0, 0, S_DEC,   O_NONE, "sw_decode");
        step(0, 1, 0, 0, S_EXEC,  O_NONE, "sw_exec");
        step(0, 1, 0, 0, S_MEM,   O_WR,   "sw_mem0");
        step(0, 1, 0, 1, S_MEM,   O_WR,   "sw_mem1_ack");
        step(0, 1, 0, 0, S_WB,    O_PC,   "sw_wb");

        // Branch follows directly from WB
        set_dec(0, 0, 0, 1);
        step(0, 1, 1, 0, S_FETCH, O_LD,         "br_fetch");
        step(0, 1, 0, 0, S_DEC,   O_NONE,       "br_decode");
        step(0, 1, 0, 1, S_EXEC,  O_NONE,       "br_exec");
        step(0, 0, 0, 0, S_WB,    O_PC | O_OFF, "br_wb");
        step(0, 0, 0, 0, S_IDLE,  O_NONE,       "br_done");

        // Load and store both set: load wins, no rd write
        set_dec(1, 1, 1, 0);
        step(0, 1, 0, 0, S_IDLE,  O_NONE, "both_idle");
        step(0, 1, 1, 0, S_FETCH, O_LD,   "both_fetch");
        step(0, 1, 0, 0, S_DEC,   O_NONE, "both_decode");
        step(0, 1, 0, 0, S_EXEC,  O_NONE, "both_exec");
        step(0, 1, 0, 1, S_MEM,   O_RD,   "both_mem");
        step(0, 0, 0, 0, S_WB,    O_PC,   "both_wb");
        step(0, 0, 0, 0, S_IDLE,  O_NONE, "both_done");

        // run dropped during MEM: instruction completes, then IDLE
        set_dec(1, 0, 1, 0);
        step(0, 1, 0, 0, S_IDLE,  O_NONE,      "drop_idle");
        step(0, 1, 1, 0, S_FETCH, O_LD,        "drop_fetch");
        step(0, 1, 0, 0, S_DEC,   O_NONE,      "drop_decode");
        step(0, 1, 0, 0, S_EXEC,  O_NONE,      "drop_exec");
        step(0, 0, 0, 0, S_MEM,   O_RD,        "drop_mem0");
        step(0, 0, 0, 1, S_MEM,   O_RD,        "drop_mem1");
        step(0, 0, 0, 0, S_WB,    O_RF | O_PC, "drop_wb");
        step(0, 0, 0, 0, S_IDLE,  O_NONE,      "drop_idle_after");

        // Two back-to-back branches take instr_cnt through 7 -> 0
        set_dec(0, 0, 0, 1);
        step(0, 1, 0, 0, S_IDLE,  O_NONE,       "wrap_idle");
        step(0, 1, 1, 0, S_FETCH, O_LD,         "wrap_fetch_a");
        step(0, 1, 0, 0, S_DEC,   O_NONE,       "wrap_decode_a");
        step(0, 1, 0, 0, S_EXEC,  O_NONE,       "wrap_exec_a");
        step(0, 1, 0, 0, S_WB,    O_PC | O_OFF, "wrap_wb_a");
        step(0, 1, 1, 0, S_FETCH, O_LD,         "wrap_fetch_b");
        step(0, 1, 0, 0, S_DEC,   O_NONE,       "wrap_decode_b");
        step(0, 1, 0, 0, S_EXEC,  O_NONE,       "wrap_exec_b");
        step(0, 0, 0, 0, S_WB,    O_PC | O_OFF, "wrap_wb_b");
        step(0, 0, 0, 0, S_IDLE,  O_NONE,       "wrap_zero");

        // Fetch timeout: 4 wait cycles then ERR, acks ignored until reset
        step(0, 1, 0, 0, S_IDLE,  O_NONE, "to_idle");
        step(0, 1, 0, 0, S_FETCH, O_REQ,  "to_fetch0");
        step(0, 1, 0, 0, S_FETCH, O_REQ,  "to_fetch1");
        step(0, 1, 0, 0, S_FETCH, O_REQ,  "to_fetch2");
        step(0, 1, 0, 0, S_FETCH, O_REQ,  "to_fetch3");
        step(0, 1, 1, 1, S_ERR,   O_ERR,  "to_err0");
        step(0, 1, 0, 0, S_ERR,   O_ERR,  "to_err1");
        step(1, 0, 0, 0, S_ERR,   O_ERR,  "to_err_rst");
        step(0, 0, 0, 0, S_IDLE,  O_NONE, "to_cleared");

        // Retire one, then reset in the middle of a load
        set_dec(0, 0, 1, 0);
        step(0, 1, 0, 0, S_IDLE,  O_NONE,      "pre_idle");
        step(0, 1, 1, 0, S_FETCH, O_LD,        "pre_fetch");
        step(0, 1, 0, 0, S_DEC,   O_NONE,      "pre_decode");
        step(0, 1, 0, 0, S_EXEC,  O_NONE,      "pre_exec");
        step(0, 1, 0, 0, S_WB,    O_RF | O_PC, "pre_wb");
        set_dec(1, 0, 1, 0);
        step(0, 1, 1, 0, S_FETCH, O_LD,        "rmem_fetch");
        step(0, 1, 0, 0, S_DEC,   O_NONE,      "rmem_decode");
        step(0, 1, 0, 0, S_EXEC,  O_NONE,      "rmem_exec");
        step(0, 1, 0, 0, S_MEM,   O_RD,        "rmem_mem");
        step(1, 1, 0, 0, S_MEM,   O_RD,        "rmem_rst");
        step(0, 0, 0, 0, S_IDLE,  O_NONE,      "rmem_after");

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
